// File: rtl/pipelined_alu.sv
// Single-stage pipelined ALU with valid/ready handshake, registered result and flags,
// and an internal accumulator for ACC/CLRACC.
module pipelined_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_XOR    = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_NAND   = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_ACC    = 3'b110;
    localparam logic [2:0] OP_CLRACC = 3'b111;

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic             accept_c;

    // The output stage frees up whenever it is empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // Result and flag computation for the presented operation.
    always_comb begin
        sum_c   = '0;
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (opcode)
            OP_XOR:  res_c = a ^ b;
            OP_ADD: begin
                sum_c   = {1'b0, a} + {1'b0, b};
                res_c   = sum_c[MSB:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (a[MSB] == b[MSB]) && (res_c[MSB] != a[MSB]);
            end
            OP_NAND: res_c = ~(a & b);
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the unsigned borrow.
                sum_c   = {1'b0, a} - {1'b0, b};
                res_c   = sum_c[MSB:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (a[MSB] != b[MSB]) && (res_c[MSB] != a[MSB]);
            end
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_ACC: begin
                sum_c   = {1'b0, acc} + {1'b0, a};
                res_c   = sum_c[MSB:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (acc[MSB] == a[MSB]) && (res_c[MSB] != acc[MSB]);
            end
            OP_CLRACC: res_c = '0;
            default:   res_c = '0;
        endcase
    end

    // Output stage and accumulator; only accepted operations update state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else begin
            if (accept_c) begin
                out_valid <= 1'b1;
                out       <= res_c;
                carry     <= carry_c;
                zero      <= (res_c == '0);
                ovf       <= ovf_c;
                if (opcode == OP_ACC) begin
                    acc <= res_c;
                end else if (opcode == OP_CLRACC) begin
                    acc <= '0;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Scoreboard bench for pipelined_alu: driver pushes model results on accept,
// monitor pops and compares whenever the DUT hands a result downstream.
module tb_pipelined_alu;

    localparam int W    = 8;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   opcode = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out;
    logic         carry;
    logic         zero;
    logic         ovf;

    exp_t q[$];
    int   macc    = 0;
    int   n_vec   = 0;
    int   n_err   = 0;
    bit   acc_now = 1'b0;

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf)
    );

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int to_s(input int u);
        return (u >= HALF) ? u - FULL : u;
    endfunction

    function automatic bit out_of_range(input int s);
        return (s > HALF - 1) || (s < -HALF);
    endfunction

    // Reference behaviour from the arithmetic definitions of each opcode.
    function automatic exp_t model(input int op, input int ua, input int ub, input int accv);
        int   r;
        bit   c;
        bit   o;
        exp_t e;
        r = 0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            0: r = ua ^ ub;
            1: begin r = ua + ub;   c = (r >= FULL); o = out_of_range(to_s(ua) + to_s(ub)); end
            2: r = (FULL - 1) - (ua & ub);
            3: begin r = ua - ub;   c = (ua < ub);   o = out_of_range(to_s(ua) - to_s(ub));
                     if (r < 0) r = r + FULL; end
            4: r = ua & ub;
            5: r = ua | ub;
            6: begin r = accv + ua; c = (r >= FULL); o = out_of_range(to_s(accv) + to_s(ua)); end
            default: r = 0;
        endcase
        r     = r % FULL;
        e.res = W'(r);
        e.c   = c;
        e.z   = (r == 0);
        e.o   = o;
        return e;
    endfunction

    // One driver cycle: present inputs at negedge, then record whether the next edge accepts.
    task automatic step(input bit r_, input bit iv, input int op, input int ua, input int ub,
                        input bit ordy, output bit accepted);
        @(negedge clk);
        rst       = r_;
        in_valid  = iv;
        opcode    = 3'(op);
        a         = W'(ua);
        b         = W'(ub);
        out_ready = ordy;
        #1;
        accepted = iv && in_ready && !r_;
        acc_now  = accepted;
        if (r_) begin
            q.delete();
            macc = 0;
        end else if (accepted) begin
            q.push_back(model(op, ua, ub, macc));
            if (op == 6)      macc = (macc + ua) % FULL;
            else if (op == 7) macc = 0;
        end
    endtask

    task automatic do_op(input int op, input int ua, input int ub, input bit ordy);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b1, op, ua, ub, ordy, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic expect_out(input string name, input int r, input int c, input int z, input int o);
        #2;
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_out"},   int'(out),       r);
        check({name, "_carry"}, int'(carry),     c);
        check({name, "_zero"},  int'(zero),      z);
        check({name, "_ovf"},   int'(ovf),       o);
    endtask

    function automatic int pick();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return FULL - 1;
            2:       return HALF;
            3:       return HALF - 1;
            default: return int'($urandom_range(0, FULL - 1));
        endcase
    endfunction

    // Monitor: compare the head of the scoreboard whenever a result is presented.
    initial begin
        int   rst_cnt;
        int   pend;
        exp_t e;
        rst_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                rst_cnt++;
                if (rst_cnt >= 2) begin
                    check("rst_out_valid", int'(out_valid), 0);
                    check("rst_out",       int'(out),       0);
                    check("rst_flags",     int'({carry, zero, ovf}), 0);
                    check("rst_in_ready",  int'(in_ready),  1);
                end
            end else begin
                rst_cnt = 0;
                check("in_ready", int'(in_ready), int'(!out_valid || out_ready));
                pend = q.size() - (acc_now ? 1 : 0);
                check("out_valid", int'(out_valid), int'(pend > 0));
                if (out_valid && pend > 0) begin
                    e = q[0];
                    check("sb_out",   int'(out),   int'(e.res));
                    check("sb_carry", int'(carry), int'(e.c));
                    check("sb_zero",  int'(zero),  int'(e.z));
                    check("sb_ovf",   int'(ovf),   int'(e.o));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    // Driver: directed scenarios, then randomized traffic with backpressure and resets.
    initial begin
        bit acc;
        int op;
        int ua;
        int ub;
        bit have;

        repeat (3) step(1'b1, 1'b0, 0, 0, 0, 1'b1, acc);

        do_op(1, 8'hF0, 8'h20, 1'b1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, acc);
        expect_out("add_f0_20", 8'h10, 1, 0, 0);

        do_op(3, 8'h80, 8'h01, 1'b1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, acc);
        expect_out("sub_80_01", 8'h7F, 0, 0, 1);
        do_op(3, 8'h05, 8'h05, 1'b1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, acc);
        expect_out("sub_05_05", 8'h00, 0, 1, 0);

        do_op(7, 0, 0, 1'b1);
        do_op(6, 8'h7F, 0, 1'b1);
        expect_out("clracc", 8'h00, 0, 1, 0);
        do_op(6, 8'h01, 0, 1'b1);
        expect_out("acc_7f", 8'h7F, 0, 0, 0);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, acc);
        expect_out("acc_80", 8'h80, 0, 0, 1);

        do_op(0, 8'hAA, 8'h55, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b1, 4, 8'h0F, 8'h3C, 1'b0, acc);
            #2;
            check("bp_no_accept", int'(acc), 0);
            check("bp_in_ready",  int'(in_ready), 0);
            check("bp_hold_out",  int'(out), 8'hFF);
        end
        step(1'b0, 1'b1, 4, 8'h0F, 8'h3C, 1'b1, acc);
        check("bp_release_accept", int'(acc), 1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, acc);
        expect_out("bp_and", 8'h0C, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, i + 1, 16 * i + 3, i + 7, 1'b1, acc);
            check("stream_accept", int'(acc), 1);
        end
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, acc);

        do_op(5, 8'h12, 8'h34, 1'b0);
        step(1'b1, 1'b1, 6, 8'h55, 0, 1'b0, acc);
        step(1'b1, 1'b1, 6, 8'h55, 0, 1'b0, acc);
        #2;
        check("rst_clears_valid", int'(out_valid), 0);
        check("rst_clears_out",   int'(out), 0);
        do_op(6, 8'h03, 0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, acc);
        expect_out("post_rst_acc", 8'h03, 0, 0, 0);

        have = 1'b0;
        op = 0; ua = 0; ub = 0;
        for (int i = 0; i < 1500; i++) begin
            bit rr;
            if (!have) begin
                op   = int'($urandom_range(0, 7));
                ua   = pick();
                ub   = pick();
                have = 1'b1;
            end
            rr = ($urandom_range(0, 99) == 0);
            step(rr, ($urandom_range(0, 3) != 0), op, ua, ub, ($urandom_range(0, 3) != 0), acc);
            if (acc) have = 1'b0;
        end

        repeat (5) step(1'b0, 1'b0, 0, 0, 0, 1'b1, acc);
        #3;
        check("drain_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
